// File: rtl/irrigation_pkg.sv
// Shared types for the tank level conditioner: consistency-FSM states and
// the three-probe level pattern with its legal values.
package irrigation_pkg;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } fsm_state_e;

  typedef struct packed {
    logic high;
    logic mid;
    logic low;
  } level_t;

  // Water fills from the bottom probe up, so only these patterns can occur.
  localparam level_t LVL_EMPTY = 3'b000;
  localparam level_t LVL_LOW   = 3'b001;
  localparam level_t LVL_MID   = 3'b011;
  localparam level_t LVL_FULL  = 3'b111;

  function automatic logic is_valid_level(input level_t lvl);
    return (lvl == LVL_EMPTY) || (lvl == LVL_LOW) ||
           (lvl == LVL_MID)   || (lvl == LVL_FULL);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One probe debouncer: the stable value flips after DEBOUNCE_TICKS
// consecutive ticks of disagreement with the raw input.
module debounce_channel #(
  parameter int unsigned DEBOUNCE_TICKS = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic tick_i,
  input  logic raw_i,
  output logic stable_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  // NOTE: every next-state signal gets its hold value first so no latch is inferred.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (tick_i) begin
      if (raw_i == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q >= CNT_LAST) begin
        // This tick would reach the threshold: flip and restart together.
        stable_d = ~stable_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/tank_level_conditioner.sv
// Debounces the three tank probes, rejects physically impossible patterns
// and publishes a registered, validated level to the tank-control FSM.
module tank_level_conditioner
  import irrigation_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 8,
  parameter int unsigned FAULT_TICKS    = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic raw_low,
  input  logic raw_mid,
  input  logic raw_high,
  output logic level_low,
  output logic level_mid,
  output logic level_high,
  output logic level_valid,
  output logic sensor_fault,
  output logic level_changed
);

  localparam int unsigned FCW = $clog2(FAULT_TICKS + 1);
  localparam int unsigned WCW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [FCW-1:0] F_LAST    = FCW'(FAULT_TICKS - 1);
  localparam logic [WCW-1:0] WARM_DONE = WCW'(DEBOUNCE_TICKS);

  logic   stable_low, stable_mid, stable_high;
  level_t stable;
  logic   pattern_ok;

  debounce_channel #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_low (
    .clock(clock), .reset(reset), .tick_i(tick), .raw_i(raw_low),  .stable_o(stable_low)
  );
  debounce_channel #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_mid (
    .clock(clock), .reset(reset), .tick_i(tick), .raw_i(raw_mid),  .stable_o(stable_mid)
  );
  debounce_channel #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_high (
    .clock(clock), .reset(reset), .tick_i(tick), .raw_i(raw_high), .stable_o(stable_high)
  );

  assign stable     = level_t'({stable_high, stable_mid, stable_low});
  assign pattern_ok = is_valid_level(stable);

  fsm_state_e     state_q, state_d;
  logic [FCW-1:0] cnt_q, cnt_d;
  logic [WCW-1:0] warm_q, warm_d;
  level_t         pub_q, pub_d;
  logic           changed_q, changed_d;
  logic           eval_q;

  // The FSM acts one clock after each tick, once the new stable values exist.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pub_d   = pub_q;
    if (eval_q) begin
      unique case (state_q)
        ST_OK: begin
          if (pattern_ok) begin
            pub_d = stable;
          end else if (FAULT_TICKS == 1) begin
            state_d = ST_FAULT;
            cnt_d   = '0;
          end else begin
            state_d = ST_SUSPECT;
            cnt_d   = FCW'(1);
          end
        end
        ST_SUSPECT: begin
          if (pattern_ok) begin
            state_d = ST_OK;
            cnt_d   = '0;
            pub_d   = stable;
          end else if (cnt_q >= F_LAST) begin
            state_d = ST_FAULT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_FAULT: begin
          // Recovery needs an unbroken run of valid ticks.
          if (!pattern_ok) begin
            cnt_d = '0;
          end else if (cnt_q >= F_LAST) begin
            state_d = ST_OK;
            cnt_d   = '0;
            pub_d   = stable;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_OK;
          cnt_d   = '0;
        end
      endcase
    end
    changed_d = (pub_d != pub_q);
    warm_d    = (tick && (warm_q != WARM_DONE)) ? warm_q + 1'b1 : warm_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_OK;
      cnt_q     <= '0;
      warm_q    <= '0;
      pub_q     <= LVL_EMPTY;
      changed_q <= 1'b0;
      eval_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      warm_q    <= warm_d;
      pub_q     <= pub_d;
      changed_q <= changed_d;
      eval_q    <= tick;
    end
  end

  assign level_low     = pub_q.low;
  assign level_mid     = pub_q.mid;
  assign level_high    = pub_q.high;
  assign level_valid   = (state_q == ST_OK) && (warm_q == WARM_DONE);
  assign sensor_fault  = (state_q == ST_FAULT);
  assign level_changed = changed_q;

endmodule

// File: tb/tb_tank_level_conditioner.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a behavioural model.
module tb_tank_level_conditioner;

  localparam int DB = 8;
  localparam int FT = 16;

  logic clock = 1'b0;
  logic reset, tick, raw_low, raw_mid, raw_high;
  logic level_low, level_mid, level_high, level_valid, sensor_fault, level_changed;

  int n_vec = 0;
  int n_miscmp = 0;

  tank_level_conditioner #(.DEBOUNCE_TICKS(DB), .FAULT_TICKS(FT)) dut (
    .clock(clock), .reset(reset), .tick(tick),
    .raw_low(raw_low), .raw_mid(raw_mid), .raw_high(raw_high),
    .level_low(level_low), .level_mid(level_mid), .level_high(level_high),
    .level_valid(level_valid), .sensor_fault(sensor_fault), .level_changed(level_changed)
  );

  always #5 clock = ~clock;

  // Behavioural model: run lengths of disagreement per probe, and run
  // lengths of bad / good evaluated patterns for the consistency check.
  int       m_run [3];
  bit       m_stab[3];
  bit       m_pend, m_fault, m_chg, m_live;
  int       m_bad, m_good, m_ticks;
  bit [2:0] m_pub;

  function automatic bit pat_ok(input bit [2:0] p);
    return (p == 3'b000) || (p == 3'b001) || (p == 3'b011) || (p == 3'b111);
  endfunction

  always @(posedge clock) begin : model
    bit [2:0] raw, stab;
    raw  = {raw_high, raw_mid, raw_low};
    stab = {m_stab[2], m_stab[1], m_stab[0]};
    if (reset) begin
      for (int i = 0; i < 3; i++) begin m_run[i] = 0; m_stab[i] = 0; end
      m_pend = 0; m_fault = 0; m_chg = 0; m_bad = 0; m_good = 0; m_ticks = 0;
      m_pub = 3'b000; m_live = 1;
    end else begin
      m_chg = 0;
      if (m_pend) begin
        if (!m_fault) begin
          if (pat_ok(stab)) begin
            m_chg = (stab != m_pub); m_pub = stab; m_bad = 0;
          end else begin
            m_bad = m_bad + 1;
            if (m_bad >= FT) begin m_fault = 1; m_good = 0; end
          end
        end else if (pat_ok(stab)) begin
          m_good = m_good + 1;
          if (m_good >= FT) begin
            m_fault = 0; m_bad = 0; m_chg = (stab != m_pub); m_pub = stab;
          end
        end else begin
          m_good = 0;
        end
      end
      if (tick) begin
        if (m_ticks < DB) m_ticks = m_ticks + 1;
        for (int i = 0; i < 3; i++) begin
          if (raw[i] != m_stab[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == DB) begin m_stab[i] = !m_stab[i]; m_run[i] = 0; end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      m_pend = tick;
    end
  end

  function automatic logic [5:0] model_vec();
    bit valid;
    valid = !m_fault && (m_bad == 0) && (m_ticks >= DB);
    return {m_pub, valid, m_fault, m_chg};
  endfunction

  function automatic logic [5:0] outs();
    return {level_high, level_mid, level_low, level_valid, sensor_fault, level_changed};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (m_live) check("model_compare", outs(), model_vec());
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  int pulses;

  initial begin
    reset = 1'b1; tick = 1'b1; raw_low = 1'b0; raw_mid = 1'b0; raw_high = 1'b0;
    step(2);
    check("reset_state", outs(), 6'b000_000);
    reset = 1'b0;
    step(7);
    check("warm_pending", outs(), 6'b000_000);
    step(1);
    check("warm_done", outs(), 6'b000_100);

    // Low probe wets: published nine clocks later with a single pulse.
    raw_low = 1'b1;
    step(8);
    check("db_low_before", outs(), 6'b000_100);
    step(1);
    check("db_low_after", outs(), 6'b001_101);
    step(1);
    check("db_low_pulse_end", outs(), 6'b001_100);

    // Mid glitch one tick short of the threshold is ignored.
    raw_mid = 1'b1;
    step(7);
    raw_mid = 1'b0;
    pulses = 0;
    repeat (12) begin step(1); pulses += int'(level_changed); end
    check("glitch_level", outs(), 6'b001_100);
    check("glitch_pulses", 6'(pulses), 6'd0);

    // Publish 011, then hold an impossible 100 until fault.
    raw_mid = 1'b1;
    step(9);
    check("mid_publish", outs(), 6'b011_101);
    raw_low = 1'b0; raw_mid = 1'b0; raw_high = 1'b1;
    step(9);
    check("suspect_entry", outs(), 6'b011_000);
    step(14);
    check("suspect_hold", outs(), 6'b011_000);
    step(1);
    check("fault_entry", outs(), 6'b011_010);

    // 15 valid ticks, one invalid, then 16 valid before recovery to 111.
    raw_mid = 1'b1; raw_low = 1'b1;
    step(15);
    raw_mid = 1'b0;
    step(1);
    raw_high = 1'b0;
    step(7);
    raw_mid = 1'b1;
    step(1);
    raw_high = 1'b1;
    step(15);
    check("fault_hold", outs(), 6'b011_010);
    step(1);
    check("fault_recover", outs(), 6'b111_101);

    // Reset with a tick while SUSPECT discards everything.
    raw_mid = 1'b0;
    step(9);
    check("suspect_again", outs(), 6'b111_000);
    reset = 1'b1; raw_low = 1'b0; raw_high = 1'b0;
    step(1);
    check("reset_in_suspect", outs(), 6'b000_000);
    reset = 1'b0;
    step(7);
    check("warm_block", outs(), 6'b000_000);
    step(1);
    check("warm_release", outs(), 6'b000_100);

    // Three ticks of progress, then 100 idle cycles of probe noise.
    raw_low = 1'b1;
    step(3);
    tick = 1'b0;
    repeat (100) begin
      raw_low = 1'($urandom); raw_mid = 1'($urandom); raw_high = 1'($urandom);
      step(1);
    end
    check("idle_hold", outs(), 6'b000_100);
    raw_low = 1'b1; raw_mid = 1'b0; raw_high = 1'b0; tick = 1'b1;
    step(5);
    check("idle_resume_before", outs(), 6'b000_100);
    step(1);
    check("idle_resume_after", outs(), 6'b001_101);

    // Randomized traffic with sparse ticks, slow probes and rare resets.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 699) == 0);
      tick  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        {raw_high, raw_mid, raw_low} = 3'($urandom);
      end else begin
        if ($urandom_range(0, 29) == 0) raw_low  = ~raw_low;
        if ($urandom_range(0, 29) == 0) raw_mid  = ~raw_mid;
        if ($urandom_range(0, 29) == 0) raw_high = ~raw_high;
      end
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
